// File: rtl/tsc_leak_pkg.sv
// rtl/tsc_leak_pkg.sv - shared types and defaults for the covert-channel leak receiver
package tsc_leak_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2
    } rx_state_t;

    // Smallest width whose all-ones value still covers a full window of activity.
    function automatic int cnt_width(input int win_len);
        return $clog2(win_len + 1);
    endfunction

    localparam int DEF_WIN_LEN  = 16;
    localparam int DEF_THRESH   = 8;
    localparam int DEF_NUM_BITS = 8;
    localparam int DEF_CNT_W    = cnt_width(DEF_WIN_LEN);

endpackage

// File: rtl/tsc_leak_receiver_if.sv
// rtl/tsc_leak_receiver_if.sv - recovered-byte valid/ready output bundle
interface tsc_leak_receiver_if #(
    parameter int NUM_BITS = 8
);
    logic [NUM_BITS-1:0] bits_out;
    logic                bits_valid;
    logic                bits_ready;
    logic                parity_out;

    modport master (
        output bits_out,
        output bits_valid,
        output parity_out,
        input  bits_ready
    );

    modport slave (
        input  bits_out,
        input  bits_valid,
        input  parity_out,
        output bits_ready
    );
endinterface

// File: rtl/tsc_win_integrator.sv
// rtl/tsc_win_integrator.sv - windowed saturating activity counter with threshold decision
import tsc_leak_pkg::*;

module tsc_win_integrator #(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int THRESH  = DEF_THRESH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic act_in,
    output logic win_done,
    output logic win_bit
);
    localparam int WC_W = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] act_cnt;
    logic [WC_W-1:0]  win_cnt;
    logic [CNT_W:0]   sum;

    // The decision includes the sample arriving on the closing cycle of the window.
    assign sum      = {1'b0, act_cnt} + {{CNT_W{1'b0}}, act_in};
    assign win_done = en && (win_cnt == WC_W'(WIN_LEN - 1));
    assign win_bit  = win_done && (sum >= (CNT_W + 1)'(THRESH));

    always_ff @(posedge clk) begin
        if (rst || !en || win_done) begin
            act_cnt <= '0;
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (act_in && act_cnt != CNT_MAX)
                act_cnt <= act_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tsc_leak_receiver.sv
// rtl/tsc_leak_receiver.sv - decodes toggle-activity windows into a byte with valid/ready output
import tsc_leak_pkg::*;

module tsc_leak_receiver #(
    parameter int WIN_LEN  = DEF_WIN_LEN,
    parameter int THRESH   = DEF_THRESH,
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                act_in,
    output logic                busy,
    tsc_leak_receiver_if.master out
);
    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    rx_state_t           state;
    logic [IDX_W-1:0]    bit_idx;
    logic [NUM_BITS-1:0] shreg;
    logic [NUM_BITS-1:0] next_bits;
    logic                win_done;
    logic                win_bit;

    tsc_win_integrator #(
        .WIN_LEN (WIN_LEN),
        .THRESH  (THRESH),
        .CNT_W   (CNT_W)
    ) u_integ (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ACQ),
        .act_in   (act_in),
        .win_done (win_done),
        .win_bit  (win_bit)
    );

    // Shift register as it will look once the closing window's bit lands.
    always_comb begin
        next_bits          = shreg;
        next_bits[bit_idx] = win_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            out.bits_valid <= 1'b0;
            out.bits_out   <= '0;
            out.parity_out <= 1'b0;
            bit_idx        <= '0;
            shreg          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACQ;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                        shreg   <= '0;
                    end
                end
                ACQ: begin
                    if (win_done) begin
                        shreg   <= next_bits;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_W'(NUM_BITS - 1)) begin
                            state          <= HOLD;
                            out.bits_out   <= next_bits;
                            out.parity_out <= ^next_bits;
                            out.bits_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out.bits_ready) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        out.bits_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    out.bits_valid <= 1'b0;
                end
            endcase
        end
    end

    act_in_known: assert property (@(posedge clk) disable iff (rst)
        (state == ACQ) |-> !$isunknown(act_in));

endmodule

// File: tb/tb_tsc_leak_receiver.sv
// tb/tb_tsc_leak_receiver.sv - self-checking bench for tsc_leak_receiver
module tb_tsc_leak_receiver;
    localparam int WIN_LEN  = 16;
    localparam int THRESH   = 8;
    localparam int NUM_BITS = 8;
    localparam int TOTAL    = WIN_LEN * NUM_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic act_in = 1'b0;
    logic busy;
    int   n_pass = 0;
    int   n_total = 0;

    tsc_leak_receiver_if #(.NUM_BITS(NUM_BITS)) rx ();

    tsc_leak_receiver #(
        .WIN_LEN  (WIN_LEN),
        .THRESH   (THRESH),
        .NUM_BITS (NUM_BITS),
        .CNT_W    (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .act_in (act_in),
        .busy   (busy),
        .out    (rx.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count active samples per window, compare to threshold.
    function automatic logic [NUM_BITS-1:0] model_bits(input logic [TOTAL-1:0] p);
        logic [NUM_BITS-1:0] r;
        for (int w = 0; w < NUM_BITS; w++) begin
            int c;
            c = 0;
            for (int j = 0; j < WIN_LEN; j++)
                c += int'(p[w*WIN_LEN + j]);
            r[w] = (c >= THRESH);
        end
        return r;
    endfunction

    function automatic logic [WIN_LEN-1:0] make_window(input int k);
        logic [WIN_LEN-1:0] v;
        v = '0;
        for (int j = 0; j < k; j++) v[j] = 1'b1;
        for (int j = WIN_LEN - 1; j > 0; j--) begin
            int s;
            logic t;
            s = $urandom_range(0, j);
            t = v[j];
            v[j] = v[s];
            v[s] = t;
        end
        return v;
    endfunction

    task automatic capture(input logic [TOTAL-1:0] pat, input bit rand_ready,
                           input int start_at, input string tag);
        logic [NUM_BITS-1:0] exp;
        exp = model_bits(pat);
        start = 1'b1;
        rx.bits_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            act_in = pat[i];
            start  = (i == start_at);
            if (rand_ready) rx.bits_ready = 1'($urandom_range(0, 1));
            if (i == TOTAL - 1) begin
                n_total++;
                if (rx.bits_valid !== 1'b0)
                    $display("FAIL %s early_valid got %b want 0", tag, rx.bits_valid);
                else n_pass++;
            end
            tick();
        end
        start = 1'b0;
        act_in = 1'b0;
        rx.bits_ready = 1'b0;
        n_total++;
        if (rx.bits_valid !== 1'b1) $display("FAIL %s valid got %b want 1", tag, rx.bits_valid);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy got %b want 1", tag, busy);
        else n_pass++;
        n_total++;
        if (rx.bits_out !== exp) $display("FAIL %s bits got %h want %h", tag, rx.bits_out, exp);
        else n_pass++;
        n_total++;
        if (rx.parity_out !== ^exp) $display("FAIL %s parity got %b want %b", tag, rx.parity_out, ^exp);
        else n_pass++;
    endtask

    task automatic release_hold(input string tag);
        rx.bits_ready = 1'b1;
        tick();
        rx.bits_ready = 1'b0;
        n_total++;
        if (rx.bits_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s release got valid=%b busy=%b want 0/0", tag, rx.bits_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        rx.bits_ready = 1'b0;
        repeat (3) tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else n_pass++;
        n_total++;
        if (rx.bits_valid !== 1'b0) $display("FAIL reset valid got %b want 0", rx.bits_valid); else n_pass++;
        n_total++;
        if (rx.bits_out !== 8'h00) $display("FAIL reset bits got %h want 00", rx.bits_out); else n_pass++;
        n_total++;
        if (rx.parity_out !== 1'b0) $display("FAIL reset parity got %b want 0", rx.parity_out); else n_pass++;
        rst = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_alternating();
        logic [TOTAL-1:0] p;
        for (int w = 0; w < NUM_BITS; w++)
            p[w*WIN_LEN +: WIN_LEN] = (w % 2 == 0) ? {WIN_LEN{1'b1}} : {WIN_LEN{1'b0}};
        capture(p, 1'b0, -1, "alternating");
        n_total++;
        if (rx.bits_out !== 8'h55) $display("FAIL alternating const got %h want 55", rx.bits_out);
        else n_pass++;
        release_hold("alternating");
    endtask

    task automatic test_threshold();
        logic [TOTAL-1:0] p;
        p = '0;
        p[0 +: WIN_LEN]       = make_window(THRESH);
        p[WIN_LEN +: WIN_LEN] = make_window(THRESH - 1);
        capture(p, 1'b0, -1, "threshold");
        n_total++;
        if (rx.bits_out !== 8'h01 || rx.parity_out !== 1'b1)
            $display("FAIL threshold const got %h/%b want 01/1", rx.bits_out, rx.parity_out);
        else n_pass++;
        release_hold("threshold");
    endtask

    task automatic test_backpressure();
        logic [TOTAL-1:0]    p;
        logic [NUM_BITS-1:0] held;
        for (int i = 0; i < TOTAL; i++) p[i] = 1'($urandom_range(0, 1));
        capture(p, 1'b0, -1, "backpressure");
        held = model_bits(p);
        for (int c = 0; c < 20; c++) begin
            start = (c == 7);
            tick();
            n_total++;
            if (rx.bits_out !== held || busy !== 1'b1 || rx.bits_valid !== 1'b1)
                $display("FAIL backpressure hold c=%0d got %h/%b/%b want %h/1/1",
                         c, rx.bits_out, busy, rx.bits_valid, held);
            else n_pass++;
        end
        start = 1'b1;
        release_hold("backpressure");
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (busy !== 1'b0) $display("FAIL backpressure restart c=%0d busy got %b want 0", c, busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [TOTAL-1:0] p;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            act_in = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (busy !== 1'b0 || rx.bits_valid !== 1'b0)
            $display("FAIL reset_mid got busy=%b valid=%b want 0/0", busy, rx.bits_valid);
        else n_pass++;
        tick();
        p = '1;
        capture(p, 1'b0, -1, "all_ones");
        n_total++;
        if (rx.bits_out !== 8'hFF || rx.parity_out !== 1'b0)
            $display("FAIL all_ones const got %h/%b want FF/0", rx.bits_out, rx.parity_out);
        else n_pass++;
        release_hold("all_ones");
    endtask

    task automatic test_start_in_acq();
        logic [TOTAL-1:0] p;
        p = '0;
        capture(p, 1'b0, 30, "start_in_acq");
        release_hold("start_in_acq");
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL start_in_acq second capture busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [TOTAL-1:0] p;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < NUM_BITS; w++)
                p[w*WIN_LEN +: WIN_LEN] = make_window($urandom_range(0, WIN_LEN));
            capture(p, 1'b1, -1, "back_to_back");
            release_hold("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_threshold();
        test_backpressure();
        test_reset_mid();
        test_start_in_acq();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
